// File: rtl/otter_dmem_arbiter.sv
// otter_dmem_arbiter
// Shares the OTTER data memory port (ADDR2 side) between the pipeline MEM
// stage (port 0) and a debug/programmer master (port 1). The granted request
// is latched so that address, size and sign stay stable through the
// synchronous-read data cycle. Read data and a completion strobe are then
// returned to the owning port.
//
// Build option: define OTTER_DMEM_ARB_RR_EN to resolve ties round-robin.
// When it is undefined, port 0 wins every tie (fixed priority).
module otter_dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // port 0: pipeline MEM stage
  input  logic              P0_REQ,
  input  logic              P0_WE,
  input  logic [ADDR_W-1:0] P0_ADDR,
  input  logic [31:0]       P0_DIN,
  input  logic [1:0]        P0_SIZE,
  input  logic              P0_SIGN,
  output logic              P0_ACK,
  output logic [31:0]       P0_DOUT,
  // port 1: debug / programmer master
  input  logic              P1_REQ,
  input  logic              P1_WE,
  input  logic [ADDR_W-1:0] P1_ADDR,
  input  logic [31:0]       P1_DIN,
  input  logic [1:0]        P1_SIZE,
  input  logic              P1_SIGN,
  output logic              P1_ACK,
  output logic [31:0]       P1_DOUT,
  // memory data port
  output logic              MEM_RDEN2,
  output logic              MEM_WE2,
  output logic [ADDR_W-1:0] MEM_ADDR2,
  output logic [31:0]       MEM_DIN2,
  output logic [1:0]        MEM_SIZE,
  output logic              MEM_SIGN,
  input  logic [31:0]       MEM_DOUT2,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t state, next_state;

  logic              any_req;
  logic              grant_sel;   // port chosen if IDLE issues this cycle
  logic              sel_we;
  logic              grant_q;     // owner of the transaction in flight
  logic              rden_q;
  logic              we_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [31:0]       p0_dout_q;
  logic [31:0]       p1_dout_q;

`ifdef OTTER_DMEM_ARB_RR_EN
  logic              last_grant_q;

  // Round-robin pointer: remembers the last port granted so the other wins a tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_q <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant_q <= grant_sel;
    end
  end
`endif

  // Arbitration: pick the port to serve from the live requests.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    any_req   = P0_REQ | P1_REQ;
    grant_sel = ~P0_REQ;
`ifdef OTTER_DMEM_ARB_RR_EN
    if (P0_REQ && P1_REQ) begin
      grant_sel = ~last_grant_q;
    end
`endif
    sel_we = grant_sel ? P1_WE : P0_WE;
  end

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a read takes two busy cycles, a write one.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any_req) next_state = sel_we ? WR : RD_ADDR;
      RD_ADDR: next_state = RD_DATA;
      RD_DATA: next_state = IDLE;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: latch the granted request, register memory strobes,
  // and capture returned read data for the owner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_q   <= 1'b0;
      rden_q    <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      size_q    <= '0;
      sign_q    <= 1'b0;
      p0_dout_q <= '0;
      p1_dout_q <= '0;
    end else begin
      // Strobes are derived from the next state so they leave a flop.
      rden_q <= (next_state == RD_ADDR);
      we_q   <= (next_state == WR);
      busy_q <= (next_state != IDLE);

      if (state == IDLE && any_req) begin
        grant_q <= grant_sel;
        addr_q  <= grant_sel ? P1_ADDR : P0_ADDR;
        din_q   <= grant_sel ? P1_DIN  : P0_DIN;
        size_q  <= grant_sel ? P1_SIZE : P0_SIZE;
        sign_q  <= grant_sel ? P1_SIGN : P0_SIGN;
      end

      if (state == RD_DATA) begin
        if (grant_q) p1_dout_q <= MEM_DOUT2;
        else         p0_dout_q <= MEM_DOUT2;
      end
    end
  end

  // Requester outputs: ACK from state and owner, DOUT bypasses memory data
  // during the completing read cycle and otherwise shows the held value.
  always_comb begin
    P0_ACK  = (state == RD_DATA || state == WR) && !grant_q;
    P1_ACK  = (state == RD_DATA || state == WR) &&  grant_q;
    P0_DOUT = (state == RD_DATA && !grant_q) ? MEM_DOUT2 : p0_dout_q;
    P1_DOUT = (state == RD_DATA &&  grant_q) ? MEM_DOUT2 : p1_dout_q;
  end

  assign MEM_RDEN2 = rden_q;
  assign MEM_WE2   = we_q;
  assign MEM_ADDR2 = addr_q;
  assign MEM_DIN2  = din_q;
  assign MEM_SIZE  = size_q;
  assign MEM_SIGN  = sign_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Testbench for otter_dmem_arbiter: a behavioural synchronous-read memory
// sits on the MEM_* side; directed requests on both ports push expected
// completions into per-port queues, and a monitor pops and compares them on
// every ACK.
module tb_otter_dmem_arbiter;

  localparam int ADDR_W = 32;

  logic              CLK = 1'b0;
  logic              RST;
  logic              P0_REQ, P0_WE, P0_SIGN, P0_ACK;
  logic [ADDR_W-1:0] P0_ADDR;
  logic [31:0]       P0_DIN, P0_DOUT;
  logic [1:0]        P0_SIZE;
  logic              P1_REQ, P1_WE, P1_SIGN, P1_ACK;
  logic [ADDR_W-1:0] P1_ADDR;
  logic [31:0]       P1_DIN, P1_DOUT;
  logic [1:0]        P1_SIZE;
  logic              MEM_RDEN2, MEM_WE2, MEM_SIGN, BUSY;
  logic [ADDR_W-1:0] MEM_ADDR2;
  logic [31:0]       MEM_DIN2, MEM_DOUT2;
  logic [1:0]        MEM_SIZE;

  otter_dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_ADDR(P0_ADDR), .P0_DIN(P0_DIN),
    .P0_SIZE(P0_SIZE), .P0_SIGN(P0_SIGN), .P0_ACK(P0_ACK), .P0_DOUT(P0_DOUT),
    .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_ADDR(P1_ADDR), .P1_DIN(P1_DIN),
    .P1_SIZE(P1_SIZE), .P1_SIGN(P1_SIGN), .P1_ACK(P1_ACK), .P1_DOUT(P1_DOUT),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2),
    .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  logic [31:0] mem [logic [29:0]];
  logic [31:0] raw_q = '0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return 32'h0;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [31:0] w;
    w = mem_read(a);
    case (sz)
      2'd0:    w[8*a[1:0] +: 8] = d[7:0];
      2'd1:    w[16*a[1] +: 16] = d[15:0];
      default: w = d;
    endcase
    mem[a[31:2]] = w;
  endtask

  function automatic logic [31:0] size_data(input logic [31:0] raw, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(raw >> (8 * a));
    h = a[1] ? raw[31:16] : raw[15:0];
    case (sz)
      2'd0:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return raw;
    endcase
  endfunction

  always @(posedge CLK) begin
    if (MEM_WE2) mem_write(MEM_ADDR2, MEM_DIN2, MEM_SIZE);
    if (MEM_RDEN2) raw_q <= mem_read(MEM_ADDR2);
  end

  always @* MEM_DOUT2 = size_data(raw_q, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

  // ---------------- bookkeeping ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] dout;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_port[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   rden_cycles = 0;
  int   we_cycles = 0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (MEM_RDEN2) rden_cycles++;
    if (MEM_WE2)   we_cycles++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic score(input int p);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_ack: port %0d acked at cycle %0d, expected no ACK", p, cyc);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("p%0d_mem_addr", p), MEM_ADDR2, e.addr);
    check($sformatf("p%0d_mem_size", p), 32'(MEM_SIZE), 32'(e.size));
    if (e.we) check($sformatf("p%0d_wr_we", p), 32'(MEM_WE2), 32'd1);
    else      check($sformatf("p%0d_rd_dout", p), (p == 0) ? P0_DOUT : P1_DOUT, e.dout);
    ack_port.push_back(p);
    ack_cyc.push_back(cyc);
  endtask

  // Monitor: compares every completion against the scoreboard.
  always @(negedge CLK) begin
    if (P0_ACK || P1_ACK) check("ack_exclusive", 32'(P0_ACK & P1_ACK), 32'd0);
    if (P0_ACK) score(0);
    if (P1_ACK) score(1);
  end

  // ---------------- requester tasks ----------------
  task automatic issue(input int p, input bit we, input logic [31:0] addr,
                       input logic [31:0] din, input logic [1:0] size, input bit uns,
                       input logic [31:0] dout, input bit push);
    exp_t e;
    e.we = we; e.addr = addr; e.size = size; e.dout = dout;
    if (p == 0) begin
      P0_WE = we; P0_ADDR = addr; P0_DIN = din; P0_SIZE = size; P0_SIGN = uns; P0_REQ = 1'b1;
      if (push) q0.push_back(e);
    end else begin
      P1_WE = we; P1_ADDR = addr; P1_DIN = din; P1_SIZE = size; P1_SIGN = uns; P1_REQ = 1'b1;
      if (push) q1.push_back(e);
    end
  endtask

  // Waits (bounded) for the port's ACK, then returns just after that edge.
  task automatic wait_ack(input int p, input int bound, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    while (!got && lat < bound) begin
      @(negedge CLK);
      lat++;
      if ((p == 0) ? P0_ACK : P1_ACK) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL ack_timeout: port %0d got no ACK in %0d cycles, expected ACK", p, bound);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic release_req(input int p);
    if (p == 0) P0_REQ = 1'b0;
    else        P1_REQ = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, base, r0, w0;

    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h104 >> 2] = 32'h12345678;
    mem[32'h108 >> 2] = 32'hCAFEF00D;
    mem[32'h10C >> 2] = 32'h0BADF00D;
    mem[32'h110 >> 2] = 32'hA5A55A5A;
    mem[32'h200 >> 2] = 32'h00000000;

    RST = 1'b1;
    P0_REQ = 0; P0_WE = 0; P0_ADDR = 0; P0_DIN = 0; P0_SIZE = 0; P0_SIGN = 0;
    P1_REQ = 0; P1_WE = 0; P1_ADDR = 0; P1_DIN = 0; P1_SIZE = 0; P1_SIGN = 0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ctrl", {27'h0, MEM_RDEN2, MEM_WE2, BUSY, P0_ACK, P1_ACK}, 32'h0);
    check("rst_addr", MEM_ADDR2, 32'h0);
    check("rst_din", MEM_DIN2, 32'h0);
    check("rst_size_sign", {29'h0, MEM_SIZE, MEM_SIGN}, 32'h0);
    check("rst_p0_dout", P0_DOUT, 32'h0);
    check("rst_p1_dout", P1_DOUT, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // P0 word load from 0x100
    r0 = rden_cycles;
    issue(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1);
    wait_ack(0, 10, lat);
    release_req(0);
    check("p0_rd_latency", 32'(lat), 32'd3);
    check("p0_rden_pulse", 32'(rden_cycles - r0), 32'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("p0_dout_held", P0_DOUT, 32'hDEADBEEF);
    check("idle_busy", 32'(BUSY), 32'd0);
    @(posedge CLK); #1;

    // P1 byte store then signed byte load
    w0 = we_cycles;
    issue(1, 1'b1, 32'h203, 32'h000000A5, 2'd0, 1'b0, 32'h0, 1'b1);
    wait_ack(1, 10, lat);
    release_req(1);
    check("p1_wr_latency", 32'(lat), 32'd2);
    check("p1_we_pulse", 32'(we_cycles - w0), 32'd1);
    issue(1, 1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 32'hFFFFFFA5, 1'b1);
    wait_ack(1, 10, lat);
    release_req(1);
    check("p0_dout_untouched", P0_DOUT, 32'hDEADBEEF);

    // Both ports streaming loads with REQ held
    base = ack_port.size();
    fork
      begin
        issue(0, 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b1);
        wait_ack(0, 40, lat);
        issue(0, 1'b0, 32'h108, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1);
        wait_ack(0, 40, lat);
        issue(0, 1'b0, 32'h10C, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 1'b1);
        wait_ack(0, 40, lat);
        release_req(0);
      end
      begin
        int lat1;
        issue(1, 1'b0, 32'h110, 32'h0, 2'd2, 1'b0, 32'hA5A55A5A, 1'b1);
        wait_ack(1, 40, lat1);
        issue(1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1);
        wait_ack(1, 40, lat1);
        release_req(1);
      end
    join
    check("stream_ack_count", 32'(ack_port.size() - base), 32'd5);
    if (ack_port.size() - base == 5) begin
`ifdef OTTER_DMEM_ARB_RR_EN
      check("stream_order", {27'h0, 1'(ack_port[base]), 1'(ack_port[base+1]), 1'(ack_port[base+2]),
                             1'(ack_port[base+3]), 1'(ack_port[base+4])}, 32'b01010);
`else
      check("stream_order", {27'h0, 1'(ack_port[base]), 1'(ack_port[base+1]), 1'(ack_port[base+2]),
                             1'(ack_port[base+3]), 1'(ack_port[base+4])}, 32'b00011);
`endif
      for (int i = 1; i < 5; i++)
        check($sformatf("stream_spacing_%0d", i), 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd3);
    end

    // Address change during RD_DATA must not disturb the transaction
    issue(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    P0_ADDR = 32'h104;
    wait_ack(0, 10, lat);
    release_req(0);
    @(negedge CLK);
    check("p0_dout_after_hold", P0_DOUT, 32'hDEADBEEF);
    @(posedge CLK); #1;

    // Reset during RD_ADDR aborts the read without an ACK
    issue(0, 1'b0, 32'h108, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_rden_before", 32'(MEM_RDEN2), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    release_req(0);
    @(negedge CLK);
    check("abort_ctrl", {28'h0, MEM_RDEN2, BUSY, P0_ACK, P1_ACK}, 32'h0);
    check("abort_p0_dout", P0_DOUT, 32'h0);
    check("abort_p1_dout", P1_DOUT, 32'h0);
    repeat (4) @(posedge CLK);
    #1;

    // First tie after reset goes to port 0 in either build
    base = ack_port.size();
    fork
      begin
        issue(0, 1'b0, 32'h108, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1);
        wait_ack(0, 20, lat);
        release_req(0);
      end
      begin
        int lat1;
        issue(1, 1'b0, 32'h10C, 32'h0, 2'd2, 1'b0, 32'h0BADF00D, 1'b1);
        wait_ack(1, 20, lat1);
        release_req(1);
      end
    join
    check("tie_ack_count", 32'(ack_port.size() - base), 32'd2);
    if (ack_port.size() - base == 2)
      check("tie_order", {30'h0, 1'(ack_port[base]), 1'(ack_port[base+1])}, 32'b01);

    // P0 store to MMIO range passes straight through
    w0 = we_cycles;
    issue(0, 1'b1, 32'h11000000, 32'h00000055, 2'd2, 1'b0, 32'h0, 1'b1);
    wait_ack(0, 10, lat);
    release_req(0);
    check("mmio_wr_latency", 32'(lat), 32'd2);
    check("mmio_we_pulse", 32'(we_cycles - w0), 32'd1);

    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
